bfly_addsub_pipe: RTL
=====================

// Module: bfly_addsub_pipe
// PURPOSE
//  Pipelined signed add/subtract stage of the radix-2 butterfly. Takes products A, B
//  from the twiddle multiplier and emits SUM=A+B and DIFF=A-B. Each 4-bit slice is
//  one cla4 per lane per stage, and carries are registered between stages.
//  Sits between the twiddle multiplier and the butterfly output register.
// PARAMETERS
//  WIDTH   16   operand/result width, signed two's complement; multiple of 4, >=8
//  NSLICE  WIDTH/4 (localparam)   pipeline depth = number of cla4 slices per lane
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      A/B valid this cycle
//  in_ready   out  1      stage can accept A/B this cycle
//  a          in   WIDTH  operand A (signed)
//  b          in   WIDTH  operand B (signed)
//  out_valid  out  1      sum/diff valid
//  out_ready  in   1      consumer accepts sum/diff
//  sum        out  WIDTH  A+B
//  diff       out  WIDTH  A-B
//  sum_ovf    out  1      signed overflow on A+B
//  diff_ovf   out  1      signed overflow on A-B
// BEHAVIOUR
//  - Reset: every valid bit, carry reg and skew reg cleared; sum=0, diff=0,
//    out_valid=0, sum_ovf=0, diff_ovf=0, in_ready=0 while rst=1.
//  - Reset mid-operation discards all in-flight items; nothing is emitted afterwards.
//  - Transfer: input on in_valid&in_ready; output on out_valid&out_ready.
//  - adv = !out_valid | out_ready. in_ready = adv & !rst. All pipeline registers,
//    including skew regs, update only when adv=1. A stall freezes the whole pipe,
//    and outputs stay stable until accepted.
//  - Latency: NSLICE cycles from input transfer to out_valid with no stall.
//    Throughput is 1 item/cycle.
//  - Stage k (0..NSLICE-1) adds bits [4k+3:4k].
//    SUM lane: cin of stage 0 = 0. DIFF lane: b inverted, cin of stage 0 = 1.
//    The cout of stage k is registered and becomes the cin of stage k+1.
//  - Operand bits for stage k>0 are delayed k cycles (input skew). Result nibble
//    from stage k is delayed NSLICE-1-k cycles (output deskew), so all nibbles of
//    one item leave together.
//  - Overflow: ovf = carry into MSB XOR carry out of MSB. Both come from the top
//    slice; the carry into the MSB is recomputed as a[W-1]^b'[W-1]^s[W-1].
//  - Width rule: result is WIDTH bits and the final cout is dropped (wrap) unless
//    saturation is enabled.
//  - A valid bubble (in_valid=0) propagates as an invalid slot. out_valid is the
//    valid bit of the last stage.
// CONFIGURATION
//  BFLY_SAT_EN defined: on overflow, the lane output clamps to 0x7FFF..F if the
//    operand sign is positive and 0x80..0 if negative. The ovf flag is still
//    asserted. The clamp adds no cycle; it is applied in the last stage's output mux.
//  BFLY_SAT_EN undefined: wrap-around result; ovf flag only.
// STRUCTURE
//  - Shared package/include bfly_defs.vh holds SLICE_W=4, the WIDTH%4 check macro,
//    and the SAT_POS/SAT_NEG constant functions of WIDTH. The FFT top and the
//    multiplier use the same file.
//  - Sub-module: bfly_slice_stage, which holds one cla4 per lane plus its carry and
//    valid registers. It is instantiated NSLICE times via generate; cla4 is reused
//    unmodified. The skew/deskew shift registers live in the top.
// TESTING (WIDTH=16, NSLICE=4)
//  1 a=0x1234,b=0x0F0F single beat, out_ready=1 -> 4 cycles later sum=0x2143,
//    diff=0x0325, ovf=0/0
//  2 a=0x7FFF,b=0x0001 -> wrap: sum=0x8000 sum_ovf=1; diff=0x7FFE diff_ovf=0;
//    with BFLY_SAT_EN: sum=0x7FFF sum_ovf=1
//  3 a=0x8000,b=0x0001 -> diff=0x7FFF diff_ovf=1 (BFLY_SAT_EN: 0x8000);
//    sum=0x8001 sum_ovf=0
//  4 back-to-back stream of 8 random pairs, with out_ready low for 3 cycles
//    mid-stream -> in_ready low during stall, outputs held stable, all 8 results in
//    order and matching the golden model, no drop or duplicate
//  5 rst asserted 2 cycles after 2 inputs are accepted -> next cycle out_valid=0,
//    all outputs 0; after release nothing is emitted until a new input, which
//    arrives after exactly 4 cycles
//  6 carry chain across all slices: a=0xFFFF,b=0x0001 -> sum=0x0000 sum_ovf=0,
//    diff=0xFFFE; a=0x0000,b=0x0000 -> diff=0x0000 (cin propagates through all
//    stages)

Source files
------------

// File: rtl/bfly_addsub_pipe_pkg.sv
// bfly_addsub_pipe_pkg: shared slice width, width check and saturation constants
//   SLICE_W       bits handled by one cla4 slice
//   width_ok()    legal operand width (multiple of SLICE_W, at least 8)
//   sat_pos/neg() largest positive / most negative value of a w-bit signed number
package bfly_addsub_pipe_pkg;
    localparam int SLICE_W = 4;
    function automatic bit width_ok(input int w);
        return (w % SLICE_W == 0) && (w >= 8);
    endfunction
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/bfly_slice_stage.sv
// bfly_slice_stage: one pipeline stage of the butterfly add/sub, one cla4 per lane
//   adv            pipeline advance enable
//   vin / vout     slot valid in / registered
//   sum_cin/co     SUM lane carry in / registered carry out
//   diff_cin/co    DIFF lane carry in / registered carry out
//   a, b           operand nibbles for this stage
//   sum, diff      registered result nibbles
// In the LAST stage the carry registers hold the signed overflow flags instead.
module bfly_slice_stage
    import bfly_addsub_pipe_pkg::*;
#(
    parameter bit LAST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               vin,
    input  logic               sum_cin,
    input  logic               diff_cin,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               vout,
    output logic               sum_co,
    output logic               diff_co,
    output logic [SLICE_W-1:0] sum,
    output logic [SLICE_W-1:0] diff
);
    logic [SLICE_W-1:0] nb, s_s, d_s;
    logic               s_c, d_c, s_nx, d_nx;
    assign nb = ~b;
    cla4 u_sum  (.a(a), .b(b),  .cin(sum_cin),  .s(s_s), .cout(s_c));
    cla4 u_diff (.a(a), .b(nb), .cin(diff_cin), .s(d_s), .cout(d_c));
    // carry into the MSB is recovered from the MSB sum bit; xor with cout gives overflow
    assign s_nx = LAST ? (a[SLICE_W-1] ^ b[SLICE_W-1] ^ s_s[SLICE_W-1] ^ s_c) : s_c;
    assign d_nx = LAST ? (a[SLICE_W-1] ^ nb[SLICE_W-1] ^ d_s[SLICE_W-1] ^ d_c) : d_c;
    always_ff @(posedge clk) begin
        if (rst) begin
            vout    <= 1'b0;
            sum_co  <= 1'b0;
            diff_co <= 1'b0;
            sum     <= '0;
            diff    <= '0;
        end else if (adv) begin
            vout    <= vin;
            sum_co  <= s_nx;
            diff_co <= d_nx;
            sum     <= s_s;
            diff    <= d_s;
        end
    end
endmodule

// File: rtl/cla4.sv
// cla4: 4-bit carry-lookahead adder
//   a, b  addends; cin carry in; s sum; cout carry out
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g, p;
    logic [3:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s = p ^ c;
endmodule

// File: rtl/bfly_addsub_pipe.sv
// bfly_addsub_pipe: pipelined signed SUM=A+B / DIFF=A-B stage of the radix-2 butterfly
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b signed operands
//   out_valid/out_ready  result handshake; sum, diff results; sum_ovf, diff_ovf overflow
// Define BFLY_SAT_EN to clamp overflowing results instead of wrapping.
module bfly_addsub_pipe
    import bfly_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] diff,
    output logic             sum_ovf,
    output logic             diff_ovf
);
    localparam int NSLICE = WIDTH / SLICE_W;
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("bfly_addsub_pipe: WIDTH must be a multiple of 4 and >= 8");
    end
    logic              adv;
    logic [NSLICE-1:0] vld, sc, dc;
    logic [WIDTH-1:0]  sum_raw, diff_raw;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign out_valid = vld[NSLICE-1];
    assign sum_ovf   = sc[NSLICE-1];
    assign diff_ovf  = dc[NSLICE-1];
    for (genvar k = 0; k < NSLICE; k++) begin : g_sl
        localparam int DK = NSLICE - 1 - k;
        logic [SLICE_W-1:0] ak, bk, sk, dk;
        logic               ci_s, ci_d, vi;
        if (k == 0) begin : g_first
            assign ak   = a[SLICE_W-1:0];
            assign bk   = b[SLICE_W-1:0];
            assign ci_s = 1'b0;
            assign ci_d = 1'b1;
            assign vi   = in_valid;
        end else begin : g_skew
            // k-deep operand skew so slice k sees its nibbles together with the carry of slice k-1
            logic [2*SLICE_W*k-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else if (adv) sr <= (sr << (2 * SLICE_W)) | (2 * SLICE_W * k)'({a[SLICE_W*k +: SLICE_W], b[SLICE_W*k +: SLICE_W]});
            end
            assign ak   = sr[2*SLICE_W*k-1 -: SLICE_W];
            assign bk   = sr[SLICE_W*(2*k-1)-1 -: SLICE_W];
            assign ci_s = sc[k-1];
            assign ci_d = dc[k-1];
            assign vi   = vld[k-1];
        end
        bfly_slice_stage #(.LAST(k == NSLICE - 1)) u_stage (
            .clk(clk), .rst(rst), .adv(adv), .vin(vi),
            .sum_cin(ci_s), .diff_cin(ci_d), .a(ak), .b(bk),
            .vout(vld[k]), .sum_co(sc[k]), .diff_co(dc[k]), .sum(sk), .diff(dk)
        );
        if (DK == 0) begin : g_last
            assign sum_raw[SLICE_W*k +: SLICE_W]  = sk;
            assign diff_raw[SLICE_W*k +: SLICE_W] = dk;
        end else begin : g_deskew
            // lower nibbles wait for the top slice so the whole word leaves at once
            logic [2*SLICE_W*DK-1:0] dr;
            always_ff @(posedge clk) begin
                if (rst) dr <= '0;
                else if (adv) dr <= (dr << (2 * SLICE_W)) | (2 * SLICE_W * DK)'({sk, dk});
            end
            assign sum_raw[SLICE_W*k +: SLICE_W]  = dr[2*SLICE_W*DK-1 -: SLICE_W];
            assign diff_raw[SLICE_W*k +: SLICE_W] = dr[SLICE_W*(2*DK-1)-1 -: SLICE_W];
        end
    end
`ifdef BFLY_SAT_EN
    localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));
    // an overflowed result has the opposite sign of the operands, so its MSB picks the clamp
    assign sum  = sum_ovf  ? (sum_raw[WIDTH-1]  ? SAT_P : SAT_N) : sum_raw;
    assign diff = diff_ovf ? (diff_raw[WIDTH-1] ? SAT_P : SAT_N) : diff_raw;
`else
    assign sum  = sum_raw;
    assign diff = diff_raw;
`endif
endmodule
